// File: rtl/adpcm_encoder_if.sv
// adpcm_encoder_if: PCM sample stream and sound-RAM write bus of the ADPCM encoder
// master (encoder side): takes pcm_in/pcm_valid, drives pcm_ready and the mem_addr/mem_data/mem_write strobe
// slave  (source/RAM side): the mirror image
interface adpcm_encoder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [11:0]           pcm_in;
    logic                  pcm_valid;
    logic                  pcm_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data;
    logic                  mem_write;
    modport master(input pcm_in, pcm_valid, output pcm_ready, mem_addr, mem_data, mem_write);
    modport slave(output pcm_in, pcm_valid, input pcm_ready, mem_addr, mem_data, mem_write);
endinterface

// File: rtl/adpcm_encoder.sv
// adpcm_encoder: 12-bit PCM to OKI/MSM5205 4-bit ADPCM, two nibbles per byte (high first) into sound RAM
// Ports: clk; reset (async, active-low); start/start_addr arm a clip at an address;
//        flush pads a pending high nibble with 0 and writes it; bus carries the PCM
//        stream and the RAM write port; last_addr is the last byte written (player end
//        address); busy is high outside IDLE.
module adpcm_encoder #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  flush,
    adpcm_encoder_if.master       bus,
    output logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, QUANT, UPDATE, WRITE} state_t;

    localparam logic [10:0] STEP [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,   11'd34,   11'd37,
        11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,
        11'd107,  11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,
        11'd279,  11'd307,  11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
        11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    state_t                state, state_nx;
    logic                  armed, phase, flush_pend, ready, xfer, flush_go;
    logic [11:0]           sample, predictor, pred_nx, delta;
    logic [5:0]            index, index_nx;
    logic [6:0]            iup;
    logic [3:0]            nib, nib_nx, hold;
    logic [7:0]            data_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [12:0]           step, d, m0, m1, m2;
    logic signed [13:0]    psum;

    assign step = {2'b00, STEP[index]};

    // Successive-approximation quantiser on |sample - predictor|
    assign d      = {sample[11], sample} - {predictor[11], predictor};
    assign m0     = d[12] ? ~d + 13'd1 : d;
    assign m1     = m0 >= step ? m0 - step : m0;
    assign m2     = m1 >= (step >> 1) ? m1 - (step >> 1) : m1;
    assign nib_nx = {d[12], m0 >= step, m1 >= (step >> 1), m2 >= (step >> 2)};

    // Decoder-identical reconstruction so the player tracks the same predictor
    assign delta   = 12'((step >> 3) + (nib[2] ? step : 13'd0) + (nib[1] ? step >> 1 : 13'd0) + (nib[0] ? step >> 2 : 13'd0));
    assign psum    = nib[3] ? $signed({{2{predictor[11]}}, predictor}) - $signed({2'b00, delta})
                            : $signed({{2{predictor[11]}}, predictor}) + $signed({2'b00, delta});
    assign pred_nx = psum > 14'sd2047 ? 12'h7FF : psum < -14'sd2048 ? 12'h800 : psum[11:0];
    assign iup      = {1'b0, index} + {4'd0, nib[1:0], 1'b0} + 7'd2;
    assign index_nx = !nib[2] ? (index == 6'd0 ? 6'd0 : index - 6'd1) : iup > 7'd48 ? 6'd48 : iup[5:0];

    assign bus.mem_addr = addr;
    assign bus.mem_data = data_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // A latched flush blocks new samples until it has been served in IDLE
    always_comb begin
        ready         = state == IDLE && armed && !flush_pend;
        xfer          = ready && bus.pcm_valid && !start;
        flush_go      = state == IDLE && !start && !xfer && phase && (flush || flush_pend);
        state_nx      = start             ? IDLE
                      : state == IDLE     ? (xfer ? QUANT : flush_go ? WRITE : IDLE)
                      : state == QUANT    ? UPDATE
                      : state == UPDATE   ? (phase ? WRITE : IDLE)
                      : IDLE;
        bus.pcm_ready = ready;
        bus.mem_write = state == WRITE;
        busy          = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            armed      <= 1'b0;
            phase      <= 1'b0;
            flush_pend <= 1'b0;
            sample     <= '0;
            predictor  <= '0;
            index      <= '0;
            nib        <= '0;
            hold       <= '0;
            data_q     <= '0;
            addr       <= '0;
            last_addr  <= '0;
        end else begin
            if (state == WRITE) last_addr <= addr;
            if (start) begin
                armed      <= 1'b1;
                phase      <= 1'b0;
                flush_pend <= 1'b0;
                predictor  <= '0;
                index      <= '0;
                addr       <= start_addr;
            end else begin
                if (xfer) sample <= bus.pcm_in;
                if (state == QUANT) nib <= nib_nx;
                if (state == UPDATE) begin
                    predictor <= pred_nx;
                    index     <= index_nx;
                    phase     <= !phase;
                    if (phase) data_q <= {hold, nib};
                    else       hold   <= nib;
                end
                if (flush_go) begin
                    data_q <= {hold, 4'h0};
                    phase  <= 1'b0;
                end
                if (state == WRITE) addr <= addr + 1'b1;
                flush_pend <= state == IDLE && !xfer ? 1'b0 : flush_pend | flush;
            end
        end
endmodule

// File: tb/tb_adpcm_encoder.sv
// tb_adpcm_encoder: directed stimulus against a cycle-level behavioural model of the ADPCM encoder
module tb_adpcm_encoder;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] last_addr;
    logic        busy;

    adpcm_encoder_if bus();

    adpcm_encoder dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .flush(flush),
        .bus(bus),
        .last_addr(last_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int STEP [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
                      107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
                      494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
    int ADJ [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    logic [7:0]  ram [65536];
    logic [23:0] wlog [$];

    // model state: what the encoder must look like, derived from the sample history
    int m_pred, m_idx, m_hold, m_addr, m_last, m_wdata, left, n;
    bit m_armed, m_phase, m_pend, wpend, idle, rdy, wexp;
    int pmax, pmin, imax;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endfunction

    function automatic int quant(int s, int pred, int idx);
        int st = STEP[idx];
        int d = s - pred;
        int m = d < 0 ? -d : d;
        int r = d < 0 ? 8 : 0;
        if (m >= st) begin r += 4; m -= st; end
        if (m >= st / 2) begin r += 2; m -= st / 2; end
        if (m >= st / 4) r += 1;
        return r;
    endfunction

    function automatic int recon(int pred, int idx, int nb);
        int st = STEP[idx];
        int dl = st / 8 + ((nb & 4) != 0 ? st : 0) + ((nb & 2) != 0 ? st / 2 : 0) + ((nb & 1) != 0 ? st / 4 : 0);
        int p = (nb & 8) != 0 ? pred - dl : pred + dl;
        return p > 2047 ? 2047 : p < -2048 ? -2048 : p;
    endfunction

    function automatic int nidx(int idx, int nb);
        int i = idx + ADJ[nb & 7];
        return i < 0 ? 0 : i > 48 ? 48 : i;
    endfunction

    // Compare process: checks the DUT against the model every cycle, then advances the model
    always @(negedge clk) begin
        if (!reset) begin
            m_armed = 0; m_phase = 0; m_pend = 0; wpend = 0;
            m_pred = 0; m_idx = 0; m_hold = 0; m_addr = 0; m_last = 0; left = 0;
        end
        idle = left == 0;
        rdy  = m_armed && idle && !m_pend;
        wexp = wpend && left == 1;
        chk("pcm_ready", int'(bus.pcm_ready), int'(rdy));
        chk("busy", int'(busy), int'(!idle));
        chk("mem_write", int'(bus.mem_write), int'(wexp));
        chk("mem_addr", int'(bus.mem_addr), m_addr);
        chk("last_addr", int'(last_addr), m_last);
        if (idle) begin
            chk("predictor", int'($signed(dut.predictor)), m_pred);
            chk("index", int'(dut.index), m_idx);
            if (int'($signed(dut.predictor)) > pmax) pmax = int'($signed(dut.predictor));
            if (int'($signed(dut.predictor)) < pmin) pmin = int'($signed(dut.predictor));
            if (int'(dut.index) > imax) imax = int'(dut.index);
        end
        if (bus.mem_write) begin
            wlog.push_back({bus.mem_addr, bus.mem_data});
            ram[bus.mem_addr] = bus.mem_data;
        end
        if (wexp) begin
            chk("mem_data", int'(bus.mem_data), m_wdata);
            m_last = m_addr;
            m_addr = (m_addr + 1) & 'hFFFF;
            wpend  = 0;
        end
        if (left > 0) left--;
        if (reset) begin
            if (start) begin
                m_armed = 1; m_phase = 0; m_pend = 0; wpend = 0;
                m_pred = 0; m_idx = 0; m_addr = int'(start_addr); left = 0;
            end else if (bus.pcm_valid && rdy) begin
                n      = quant(int'($signed(bus.pcm_in)), m_pred, m_idx);
                m_pred = recon(m_pred, m_idx, n);
                m_idx  = nidx(m_idx, n);
                if (!m_phase) begin m_hold = n; left = 2; end
                else begin m_wdata = m_hold * 16 + n; left = 3; wpend = 1; end
                m_phase = !m_phase;
                m_pend  = flush;
            end else if (idle && (flush || m_pend)) begin
                if (m_phase) begin m_wdata = m_hold * 16; m_phase = 0; left = 1; wpend = 1; end
                m_pend = 0;
            end else if (flush) m_pend = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int k = 0;
        while (!bus.pcm_ready && k < 40) begin tick(); k++; end
        chk("settle_ready", int'(bus.pcm_ready), 1);
    endtask

    task automatic send(int s);
        int k = 0;
        while (!bus.pcm_ready && k < 40) begin tick(); k++; end
        if (!bus.pcm_ready) begin
            chk("send_ready_timeout", int'(bus.pcm_ready), 1);
            return;
        end
        bus.pcm_in    = 12'(s);
        bus.pcm_valid = 1'b1;
        tick();
        bus.pcm_valid = 1'b0;
    endtask

    task automatic do_start(logic [15:0] a);
        start_addr = a;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, rp, ri, nn;
        int preds [$];
        logic [23:0] w;
        logic [7:0]  b;
        bus.pcm_in    = '0;
        bus.pcm_valid = 1'b0;
        repeat (2) tick();
        chk("rst_pcm_ready", int'(bus.pcm_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_write", int'(bus.mem_write), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_mem_data", int'(bus.mem_data), 0);
        chk("rst_last_addr", int'(last_addr), 0);
        reset = 1'b1;
        tick();
        chk("unarmed_ready", int'(bus.pcm_ready), 0);

        // two samples +100,+100 -> 0x77 at 0x0100
        do_start(16'h0100);
        chk("start_ready", int'(bus.pcm_ready), 1);
        chk("start_addr", int'(bus.mem_addr), 'h0100);
        send(100);
        send(100);
        settle();
        chk("t1_count", wlog.size(), 1);
        w = wlog[wlog.size() - 1];
        chk("t1_addr", int'(w[23:8]), 'h0100);
        chk("t1_data", int'(w[7:0]), 'h77);
        chk("t1_pred", int'($signed(dut.predictor)), 93);
        chk("t1_index", int'(dut.index), 16);
        chk("t1_model_pred", m_pred, 93);
        chk("t1_model_index", m_idx, 16);
        chk("t1_last_addr", int'(last_addr), 'h0100);
        chk("t1_mem_addr", int'(bus.mem_addr), 'h0101);

        // negative sample then flush -> 0xF0
        do_start(16'h0200);
        nb = wlog.size();
        send(-100);
        settle();
        repeat (4) tick();
        chk("t2_no_early_write", wlog.size(), nb);
        chk("t2_pred", int'($signed(dut.predictor)), -30);
        do_flush();
        settle();
        chk("t2_count", wlog.size(), nb + 1);
        w = wlog[wlog.size() - 1];
        chk("t2_addr", int'(w[23:8]), 'h0200);
        chk("t2_data", int'(w[7:0]), 'hF0);
        chk("t2_pred_after_flush", int'($signed(dut.predictor)), -30);

        // silence: predictor toggles 0 -> 2 -> 0, each byte is {0,8}
        do_start(16'h0300);
        nb = wlog.size();
        repeat (4) send(0);
        settle();
        chk("t3_count", wlog.size(), nb + 2);
        w = wlog[nb];
        chk("t3_w0", int'(w), 'h030008);
        w = wlog[nb + 1];
        chk("t3_w1", int'(w), 'h030108);
        chk("t3_index", int'(dut.index), 0);
        chk("t3_pred", int'($signed(dut.predictor)), 0);

        // saturation
        do_start(16'h1000);
        nb = wlog.size();
        pmax = -99999; pmin = 99999; imax = 0;
        repeat (200) send(2047);
        repeat (200) send(-2048);
        settle();
        chk("t4_bytes", wlog.size() - nb, 200);
        chk("t4_pmax", pmax, 2047);
        chk("t4_pmin", pmin, -2048);
        chk("t4_imax", imax, 48);

        // address wrap
        do_start(16'hFFFF);
        nb = wlog.size();
        send(500); send(-300); send(50); send(1000);
        settle();
        chk("t5_count", wlog.size(), nb + 2);
        w = wlog[nb];
        chk("t5_addr0", int'(w[23:8]), 'hFFFF);
        w = wlog[nb + 1];
        chk("t5_addr1", int'(w[23:8]), 'h0000);
        chk("t5_mem_addr", int'(bus.mem_addr), 1);

        // start during UPDATE of an even nibble aborts the write
        do_start(16'h2000);
        nb = wlog.size();
        send(300);
        send(600);
        tick();
        chk("t5_in_update", int'(busy), 1);
        do_start(16'h2100);
        repeat (6) tick();
        chk("t5_abort_count", wlog.size(), nb);
        chk("t5_abort_addr", int'(bus.mem_addr), 'h2100);
        chk("t5_abort_pred", int'($signed(dut.predictor)), 0);

        // flush together with a transfer runs after the sample
        do_start(16'h3000);
        nb = wlog.size();
        bus.pcm_in    = 12'd200;
        bus.pcm_valid = 1'b1;
        flush         = 1'b1;
        tick();
        bus.pcm_valid = 1'b0;
        flush         = 1'b0;
        settle();
        chk("t6_count", wlog.size(), nb + 1);
        w = wlog[wlog.size() - 1];
        chk("t6_w", int'(w), 'h300070);
        do_flush();
        repeat (3) tick();
        chk("t6_flush_even_noop", wlog.size(), nb + 1);

        // asynchronous reset mid-sample
        do_start(16'h4000);
        nb = wlog.size();
        send(700);
        reset = 1'b0;
        #1;
        chk("t7_busy", int'(busy), 0);
        chk("t7_ready", int'(bus.pcm_ready), 0);
        chk("t7_mem_addr", int'(bus.mem_addr), 0);
        chk("t7_last_addr", int'(last_addr), 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("t7_ready_unarmed", int'(bus.pcm_ready), 0);
        chk("t7_no_write", wlog.size(), nb);

        // round trip: decode the written bytes and compare with the encoder's predictor trace
        do_start(16'h5000);
        for (int k = 0; k < 256; k++) begin
            send($rtoi(1500.0 * $sin(2.0 * 3.14159265 * k / 32.0)));
            settle();
            preds.push_back(int'($signed(dut.predictor)));
        end
        chk("t8_last_addr", int'(last_addr), 'h5000 + 127);
        rp = 0;
        ri = 0;
        for (int k = 0; k < 256; k++) begin
            b  = ram[16'(16'h5000 + k / 2)];
            nn = (k % 2) != 0 ? int'(b[3:0]) : int'(b[7:4]);
            rp = recon(rp, ri, nn);
            ri = nidx(ri, nn);
            chk("t8_roundtrip", rp, preds[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
